// File: rtl/issue_ctrl.sv
// issue_ctrl: issues one registered instruction per cycle from fetch to the
// decode control block. Inserts NOP bubbles on load-use hazards, squashes the
// words fetched in a jump shadow, and freezes entirely while dcb_hold is high.
//
// Handshake: a fetch word transfers on a rising edge where fetch_vld and
// fetch_rdy are both 1. fetch_rdy never depends on anything the fetch side
// drives except through the hazard check (a dependent word is refused in the
// same cycle). The fetch side keeps fetch_ins stable until it is accepted.
module issue_ctrl #(
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          LDU_STALL = 1,
  parameter int          FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_vld,
  input  logic [31:0] fetch_ins,
  output logic        fetch_rdy,
  input  logic        dcb_hold,
  output logic [31:0] ins_dcb,
  output logic        ins_dcb_vld,
  output logic [15:0] bubble_cnt,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_JMP = 6'b011000;

  localparam logic [15:0] STALL_LOAD = 16'(LDU_STALL - 1);
  localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYC);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        prev_ld;
  logic [4:0]  prev_rd;

  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_imm;
  logic        in_jump;
  logic        in_ld;
  logic        hazard;

  assign state_dbg = state;

  // Decode the presented fetch word and evaluate the load-use hazard.
  // Bubbles clear prev_ld, so a hazard can never chain off a NOP.
  always_comb begin
    in_op   = fetch_ins[31:26];
    in_rd   = fetch_ins[25:21];
    in_rs1  = fetch_ins[20:16];
    in_rs2  = fetch_ins[15:11];
    in_imm  = (in_op[5:3] == 3'b001);
    in_jump = (in_op == OP_JMP) || (in_op[5:2] == 4'b0111);
    in_ld   = (in_op == OP_LD);
    hazard  = fetch_vld && prev_ld &&
              ((in_rs1 == prev_rd) || (!in_imm && (in_rs2 == prev_rd)));
  end

  // Ready: low in reset, hold, stall, and when the presented word is dependent.
  always_comb begin
    fetch_rdy = 1'b0;
    if (reset && !dcb_hold) begin
      case (state)
        ISSUE:   fetch_rdy = !hazard;
        FLUSH:   fetch_rdy = 1'b1;
        default: fetch_rdy = 1'b0;
      endcase
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Issue pipeline register, FSM, counters and saved load destination.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ISSUE;
      ins_dcb     <= NOP_WORD;
      ins_dcb_vld <= 1'b0;
      bubble_cnt  <= 16'd0;
      cnt         <= 16'd0;
      prev_ld     <= 1'b0;
      prev_rd     <= 5'd0;
    end else if (!dcb_hold) begin
      case (state)
        ISSUE: begin
          if (!fetch_vld) begin
            ins_dcb     <= NOP_WORD;
            ins_dcb_vld <= 1'b0;
            prev_ld     <= 1'b0;
          end else if (hazard) begin
            ins_dcb     <= NOP_WORD;
            ins_dcb_vld <= 1'b0;
            prev_ld     <= 1'b0;
            bubble_cnt  <= sat_inc(bubble_cnt);
            cnt         <= STALL_LOAD;
            state       <= (LDU_STALL > 1) ? STALL : ISSUE;
          end else begin
            ins_dcb     <= fetch_ins;
            ins_dcb_vld <= 1'b1;
            prev_ld     <= in_ld;
            prev_rd     <= in_rd;
            if (in_jump) begin
              cnt   <= FLUSH_LOAD;
              state <= FLUSH;
            end
          end
        end
        STALL, FLUSH: begin
          // Both drain cnt one bubble per cycle; FLUSH also swallows fetch words.
          ins_dcb     <= NOP_WORD;
          ins_dcb_vld <= 1'b0;
          prev_ld     <= 1'b0;
          bubble_cnt  <= sat_inc(bubble_cnt);
          cnt         <= cnt - 16'd1;
          if (cnt <= 16'd1) state <= ISSUE;
        end
        default: begin
          ins_dcb     <= NOP_WORD;
          ins_dcb_vld <= 1'b0;
          prev_ld     <= 1'b0;
          state       <= ISSUE;
        end
      endcase
    end
  end

endmodule
